// File: rtl/vend_pkg.sv
// vend_pkg: shared types, coin encoding and widths for the vending controller
package vend_pkg;
  localparam int CREDIT_W = 8;
  localparam int TICK_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE} state_t;
  localparam logic [1:0] COIN_5 = 2'b00;
  localparam logic [1:0] COIN_10 = 2'b01;
  localparam logic [1:0] COIN_25 = 2'b10;
  localparam logic [1:0] COIN_100 = 2'b11;
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    return code == COIN_5 ? 8'd5 : code == COIN_10 ? 8'd10 : code == COIN_25 ? 8'd25 : 8'd100;
  endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: customer-side coin/select/cancel inputs and vend/change outputs
interface vend_if;
  import vend_pkg::*;
  logic coin_valid;
  logic [1:0] coin_code;
  logic sel_valid;
  logic [1:0] sel_item;
  logic cancel;
  logic [CREDIT_W-1:0] credit;
  logic coin_reject;
  logic sel_err;
  logic dispense;
  logic [1:0] item_out;
  logic change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic busy;
  modport master(
    output coin_valid, coin_code, sel_valid, sel_item, cancel,
    input credit, coin_reject, sel_err, dispense, item_out, change_valid, change_amt, busy
  );
  modport slave(
    input coin_valid, coin_code, sel_valid, sel_item, cancel,
    output credit, coin_reject, sel_err, dispense, item_out, change_valid, change_amt, busy
  );
endinterface

// File: rtl/vend_tick_timer.sv
// vend_tick_timer: clk_en tick counter with clear and terminal count at a loaded limit
module vend_tick_timer
  import vend_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              run,
  input  logic              tick,
  input  logic [TICK_W-1:0] limit,
  output logic              done
);
  logic [TICK_W-1:0] cnt;
  assign done = run && tick && cnt == limit - TICK_W'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run && tick) cnt <= cnt + TICK_W'(1);
endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin credit, priced selection, timed dispense/change and timeout refund
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_A = 50,
  parameter int PRICE_B = 75,
  parameter int PRICE_C = 100,
  parameter int PRICE_D = 125,
  parameter int MAX_CREDIT = 200,
  parameter int DISP_TICKS = 3,
  parameter int TIMEOUT_TICKS = 30
) (
  input logic clk,
  input logic reset,
  input logic clk_en,
  vend_if.slave bus
);
  state_t state, nxt;
  logic [CREDIT_W-1:0] credit_n, amt_n, coin_v, price;
  logic [CREDIT_W:0] sum;
  logic [1:0] item_n;
  logic rej_n, err_n, acc, done;
  assign coin_v = coin_value(bus.coin_code);
  assign sum = {1'b0, bus.credit} + {1'b0, coin_v};
  assign price = bus.sel_item == 2'd0 ? CREDIT_W'(PRICE_A) :
                 bus.sel_item == 2'd1 ? CREDIT_W'(PRICE_B) :
                 bus.sel_item == 2'd2 ? CREDIT_W'(PRICE_C) : CREDIT_W'(PRICE_D);
  assign bus.dispense = state == S_DISPENSE;
  assign bus.change_valid = state == S_CHANGE;
  assign bus.busy = bus.dispense || bus.change_valid;
  // One timer serves both phases; any state change or accepted coin restarts it
  vend_tick_timer u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (nxt != state || acc),
    .run  (state == S_CREDIT || state == S_DISPENSE),
    .tick (clk_en),
    .limit(state == S_DISPENSE ? TICK_W'(DISP_TICKS) : TICK_W'(TIMEOUT_TICKS)),
    .done (done)
  );
  always_comb begin
    nxt = state;
    credit_n = bus.credit;
    amt_n = bus.change_amt;
    item_n = bus.item_out;
    rej_n = 1'b0;
    err_n = 1'b0;
    acc = 1'b0;
    case (state)
      S_IDLE: if (bus.coin_valid) begin
        credit_n = coin_v;
        acc = 1'b1;
        nxt = S_CREDIT;
      end
      S_CREDIT: if (bus.cancel || done) begin
        amt_n = bus.credit;
        credit_n = '0;
        rej_n = bus.coin_valid;
        nxt = S_CHANGE;
      end else if (bus.coin_valid) begin
        acc = sum <= (CREDIT_W+1)'(MAX_CREDIT);
        rej_n = !acc;
        credit_n = acc ? sum[CREDIT_W-1:0] : bus.credit;
      end else if (bus.sel_valid) begin
        if (bus.credit >= price) begin
          item_n = bus.sel_item;
          amt_n = bus.credit - price;
          credit_n = '0;
          nxt = S_DISPENSE;
        end else err_n = 1'b1;
      end
      S_DISPENSE: begin
        rej_n = bus.coin_valid;
        if (done) nxt = bus.change_amt != '0 ? S_CHANGE : S_IDLE;
      end
      default: begin
        rej_n = bus.coin_valid;
        if (clk_en) begin
          amt_n = '0;
          nxt = S_IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      bus.credit <= '0;
      bus.change_amt <= '0;
      bus.item_out <= '0;
      bus.coin_reject <= 1'b0;
      bus.sel_err <= 1'b0;
    end else begin
      state <= nxt;
      bus.credit <= credit_n;
      bus.change_amt <= amt_n;
      bus.item_out <= item_n;
      bus.coin_reject <= rej_n;
      bus.sel_err <= err_n;
    end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed vectors with hand-computed expectations for vend_controller
module tb_vend_controller;
  import vend_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_en = 1'b0;
  logic en_hi = 1'b0;
  logic [1:0] ph = 2'd0;
  int n_chk = 0;
  int n_fail = 0;
  int dt, dc, ct, itm, amt;
  vend_if bus();
  vend_controller dut (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1;
    ph = ph + 2'd1;
    clk_en = en_hi || ph == 2'd0;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic coin(input logic [1:0] c);
    bus.coin_valid = 1'b1;
    bus.coin_code = c;
    @(negedge clk);
    bus.coin_valid = 1'b0;
  endtask
  task automatic sel(input logic [1:0] i);
    bus.sel_valid = 1'b1;
    bus.sel_item = i;
    @(negedge clk);
    bus.sel_valid = 1'b0;
  endtask
  task automatic cancel_coin(input logic with_coin, input logic [1:0] c);
    bus.cancel = 1'b1;
    bus.coin_valid = with_coin;
    bus.coin_code = c;
    @(negedge clk);
    bus.cancel = 1'b0;
    bus.coin_valid = 1'b0;
  endtask
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n;) begin
      if (clk_en) k++;
      @(negedge clk);
    end
  endtask
  // Follows a vend to IDLE, counting dispense ticks/cycles and change ticks
  task automatic run_out(output int o_dt, output int o_dc, output int o_ct, output int o_itm, output int o_amt);
    o_dt = 0; o_dc = 0; o_ct = 0; o_itm = -1; o_amt = -1;
    for (int i = 0; i < 400 && bus.busy; i++) begin
      if (bus.dispense) begin
        o_dc++;
        o_itm = int'(bus.item_out);
        if (clk_en) o_dt++;
      end
      if (bus.change_valid) begin
        o_amt = int'(bus.change_amt);
        if (clk_en) o_ct++;
      end
      @(negedge clk);
    end
    check("drain_busy", int'(bus.busy), 0);
    check("drain_credit", int'(bus.credit), 0);
  endtask
  initial begin
    bus.coin_valid = 1'b0; bus.coin_code = 2'd0;
    bus.sel_valid = 1'b0; bus.sel_item = 2'd0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_credit", int'(bus.credit), 0);
    check("rst_dispense", int'(bus.dispense), 0);
    check("rst_change", int'(bus.change_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_flags", int'({bus.coin_reject, bus.sel_err, bus.item_out, bus.change_amt}), 0);
    reset = 1'b1;
    @(negedge clk);
    coin(COIN_25);
    check("t1_credit25", int'(bus.credit), 25);
    coin(COIN_25);
    check("t1_credit50", int'(bus.credit), 50);
    sel(2'd0);
    check("t1_disp", int'(bus.dispense), 1);
    check("t1_credit0", int'(bus.credit), 0);
    run_out(dt, dc, ct, itm, amt);
    check("t1_ticks", dt, 3);
    check("t1_item", itm, 0);
    check("t1_nochange", ct, 0);
    coin(COIN_100);
    coin(COIN_25);
    check("t2_credit", int'(bus.credit), 125);
    sel(2'd1);
    run_out(dt, dc, ct, itm, amt);
    check("t2_ticks", dt, 3);
    check("t2_item", itm, 1);
    check("t2_chg_ticks", ct, 1);
    check("t2_chg_amt", amt, 50);
    check("t2_amt_clr", int'(bus.change_amt), 0);
    coin(COIN_10);
    sel(2'd3);
    check("t3_selerr", int'(bus.sel_err), 1);
    check("t3_credit", int'(bus.credit), 10);
    @(negedge clk);
    check("t3_selerr_pulse", int'(bus.sel_err), 0);
    cancel_coin(1'b0, COIN_5);
    check("t3_chg_valid", int'(bus.change_valid), 1);
    check("t3_chg_amt", int'(bus.change_amt), 10);
    check("t3_credit0", int'(bus.credit), 0);
    run_out(dt, dc, ct, itm, amt);
    check("t3_chg_ticks", ct, 1);
    coin(COIN_100);
    coin(COIN_100);
    check("t4_credit200", int'(bus.credit), 200);
    coin(COIN_5);
    check("t4_reject_over", int'(bus.coin_reject), 1);
    check("t4_credit_kept", int'(bus.credit), 200);
    sel(2'd3);
    coin(COIN_10);
    check("t4_reject_disp", int'(bus.coin_reject), 1);
    check("t4_still_disp", int'(bus.dispense), 1);
    run_out(dt, dc, ct, itm, amt);
    check("t4_item", itm, 3);
    check("t4_chg_amt", amt, 75);
    coin(COIN_25);
    wait_ticks(29);
    check("t5_no_refund29", int'(bus.change_valid), 0);
    check("t5_credit", int'(bus.credit), 25);
    wait_ticks(1);
    check("t5_refund", int'(bus.change_valid), 1);
    check("t5_refund_amt", int'(bus.change_amt), 25);
    run_out(dt, dc, ct, itm, amt);
    coin(COIN_25);
    wait_ticks(29);
    coin(COIN_5);
    check("t5_credit30", int'(bus.credit), 30);
    wait_ticks(29);
    check("t5_restart", int'(bus.change_valid), 0);
    wait_ticks(1);
    check("t5_refund2", int'(bus.change_valid), 1);
    check("t5_refund2_amt", int'(bus.change_amt), 30);
    run_out(dt, dc, ct, itm, amt);
    coin(COIN_10);
    cancel_coin(1'b1, COIN_100);
    check("t6_reject", int'(bus.coin_reject), 1);
    check("t6_chg_valid", int'(bus.change_valid), 1);
    check("t6_chg_amt", int'(bus.change_amt), 10);
    run_out(dt, dc, ct, itm, amt);
    coin(COIN_100);
    sel(2'd2);
    check("t7_disp", int'(bus.dispense), 1);
    #2 reset = 1'b0;
    #1;
    check("t7_rst_disp", int'(bus.dispense), 0);
    check("t7_rst_busy", int'(bus.busy), 0);
    check("t7_rst_item", int'(bus.item_out), 0);
    check("t7_rst_amt", int'(bus.change_amt), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t7_no_change", int'(bus.change_valid), 0);
    check("t7_credit", int'(bus.credit), 0);
    en_hi = 1'b1;
    repeat (2) @(negedge clk);
    coin(COIN_25);
    coin(COIN_25);
    coin(COIN_25);
    check("t8_credit", int'(bus.credit), 75);
    sel(2'd0);
    run_out(dt, dc, ct, itm, amt);
    check("t8_disp_clks", dc, 3);
    check("t8_chg_ticks", ct, 1);
    check("t8_chg_amt", amt, 25);
    en_hi = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
